// File: rtl/shape_motion_sequencer.sv
// Purpose  : per-frame motion controller for N_OBJ shape centres (velocity step, edge bounce, atomic commit).
// Latency  : frame start accepted on enabled cycle T; committed centres change at enabled cycle T+N_OBJ+1.
// Backpress: none; frame starts while busy are dropped (o_overrun), config writes while busy are dropped (no ack).
//
// Ports:
//   i_clk, i_rst                 clock and synchronous active-high reset (reset ignores i_clkenable)
//   i_clkenable                  pixel-rate enable; all non-reset state advances only when high
//   i_frame_start                start-of-vblank pulse, begins one update pass
//   i_cfg_we/idx/x/y/vx/vy       slot load port, accepted only in IDLE; o_cfg_ack pulses on accept
//   o_xcenter, o_ycenter         committed centres, slot k in bits [10k+9:10k]
//   o_busy, o_done, o_overrun    pass in progress / commit pulse / frame start while busy
//
// Build option: define SHAPE_MOTION_GRAVITY_EN to add +1 (saturating at +7) to vy on every update.
module shape_motion_sequencer #(
  parameter int N_OBJ  = 4,
  parameter int X_MAX  = 640,
  parameter int Y_MAX  = 480,
  parameter int RADIUS = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clkenable,
  input  logic                 i_frame_start,
  input  logic                 i_cfg_we,
  input  logic [2:0]           i_cfg_idx,
  input  logic [9:0]           i_cfg_x,
  input  logic [9:0]           i_cfg_y,
  input  logic [3:0]           i_cfg_vx,
  input  logic [3:0]           i_cfg_vy,
  output logic                 o_cfg_ack,
  output logic [10*N_OBJ-1:0]  o_xcenter,
  output logic [10*N_OBJ-1:0]  o_ycenter,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_overrun
);

  localparam int IW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1;
  localparam logic [IW-1:0]     LAST_IDX = IW'(N_OBJ - 1);
  localparam logic [9:0]        X_MID    = 10'(X_MAX / 2);
  localparam logic [9:0]        Y_MID    = 10'(Y_MAX / 2);
  localparam logic signed [11:0] LO_LIM  = 12'(RADIUS);
  localparam logic signed [11:0] X_HI    = 12'(X_MAX - 1 - RADIUS);
  localparam logic signed [11:0] Y_HI    = 12'(Y_MAX - 1 - RADIUS);

  typedef struct packed {
    logic [9:0]        x;
    logic [9:0]        y;
    logic signed [3:0] vx;
    logic signed [3:0] vy;
  } obj_t;

  typedef struct packed {
    logic [9:0]        pos;
    logic signed [3:0] vel;
  } axis_t;

  typedef enum logic [1:0] {S_IDLE, S_UPDATE, S_COMMIT} state_t;

  // Negating -8 has no 4-bit representation, so it saturates to +7.
  function automatic logic signed [3:0] neg_sat(input logic signed [3:0] v);
    return (v == $signed(4'b1000)) ? 4'sd7 : -v;
  endfunction

  // One axis step. The sum is kept 12 bits wide so an unclamped config position
  // near 1023 plus a positive velocity cannot wrap negative before the clamp.
  function automatic axis_t step_axis(input logic [9:0] p, input logic signed [3:0] v,
                                      input logic signed [11:0] hi);
    logic signed [11:0] n;
    axis_t r;
    n     = $signed({2'b00, p}) + $signed({{8{v[3]}}, v});
    r.pos = n[9:0];
    r.vel = v;
    if (n < LO_LIM) begin
      r.pos = LO_LIM[9:0];
      r.vel = neg_sat(v);
    end else if (n > hi) begin
      r.pos = hi[9:0];
      r.vel = neg_sat(v);
    end
    return r;
  endfunction

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q;
  obj_t            obj_q [N_OBJ];

  logic            start_c, upd_c, commit_c, cfg_acc_c, ovr_c;
  logic            cfg_in_range;
  logic [IW-1:0]   cfg_slot;
  obj_t            cur_obj, upd_obj;
  axis_t           ax, ay;
  logic signed [3:0] vy_eff;

  assign cfg_in_range = ({1'b0, i_cfg_idx} < 4'(N_OBJ));
  assign cfg_slot     = i_cfg_idx[IW-1:0];
  assign o_busy       = (state_q == S_UPDATE);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and per-cycle control strobes (all gated by the enable)
  always_comb begin
    state_d   = state_q;
    start_c   = 1'b0;
    upd_c     = 1'b0;
    commit_c  = 1'b0;
    cfg_acc_c = 1'b0;
    ovr_c     = 1'b0;
    if (i_clkenable) begin
      case (state_q)
        S_IDLE: begin
          cfg_acc_c = i_cfg_we && cfg_in_range;
          if (i_frame_start) begin
            start_c = 1'b1;
            state_d = S_UPDATE;
          end
        end
        S_UPDATE: begin
          upd_c = 1'b1;
          ovr_c = i_frame_start;
          if (idx_q == LAST_IDX) state_d = S_COMMIT;
        end
        S_COMMIT: begin
          commit_c = 1'b1;
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Motion step for the slot currently addressed by idx_q
  always_comb begin
    cur_obj = obj_q[idx_q];
`ifdef SHAPE_MOTION_GRAVITY_EN
    vy_eff = (cur_obj.vy == 4'sd7) ? 4'sd7 : cur_obj.vy + 4'sd1;
`else
    vy_eff = cur_obj.vy;
`endif
    ax      = step_axis(cur_obj.x, cur_obj.vx, X_HI);
    ay      = step_axis(cur_obj.y, vy_eff, Y_HI);
    upd_obj = '{x: ax.pos, y: ay.pos, vx: ax.vel, vy: ay.vel};
  end

  // Working slots, committed centres and pulse outputs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < N_OBJ; k++) begin
        obj_q[k]             <= '{x: X_MID, y: Y_MID, vx: 4'sd0, vy: 4'sd0};
        o_xcenter[10*k +: 10] <= X_MID;
        o_ycenter[10*k +: 10] <= Y_MID;
      end
      idx_q     <= '0;
      o_cfg_ack <= 1'b0;
      o_done    <= 1'b0;
      o_overrun <= 1'b0;
    end else begin
      o_cfg_ack <= 1'b0;
      o_done    <= 1'b0;
      o_overrun <= 1'b0;
      // A write in the same cycle as a frame start lands before the first update.
      if (cfg_acc_c) begin
        obj_q[cfg_slot] <= '{x: i_cfg_x, y: i_cfg_y, vx: $signed(i_cfg_vx), vy: $signed(i_cfg_vy)};
        o_cfg_ack       <= 1'b1;
      end
      if (start_c) idx_q <= '0;
      if (upd_c) begin
        obj_q[idx_q] <= upd_obj;
        idx_q        <= idx_q + 1'b1;
      end
      if (commit_c) begin
        for (int k = 0; k < N_OBJ; k++) begin
          o_xcenter[10*k +: 10] <= obj_q[k].x;
          o_ycenter[10*k +: 10] <= obj_q[k].y;
        end
        o_done <= 1'b1;
      end
      if (ovr_c) o_overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_shape_motion_sequencer.sv
// Directed bench for shape_motion_sequencer with default parameters (N_OBJ=4, 640x480, RADIUS=16).
module tb_shape_motion_sequencer;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_clkenable = 1'b1;
  logic        i_frame_start = 1'b0;
  logic        i_cfg_we = 1'b0;
  logic [2:0]  i_cfg_idx = '0;
  logic [9:0]  i_cfg_x = '0;
  logic [9:0]  i_cfg_y = '0;
  logic [3:0]  i_cfg_vx = '0;
  logic [3:0]  i_cfg_vy = '0;
  logic        o_cfg_ack;
  logic [39:0] o_xcenter;
  logic [39:0] o_ycenter;
  logic        o_busy, o_done, o_overrun;

  int checks = 0;
  int errors = 0;

  shape_motion_sequencer dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_clkenable(i_clkenable), .i_frame_start(i_frame_start),
    .i_cfg_we(i_cfg_we), .i_cfg_idx(i_cfg_idx), .i_cfg_x(i_cfg_x), .i_cfg_y(i_cfg_y),
    .i_cfg_vx(i_cfg_vx), .i_cfg_vy(i_cfg_vy), .o_cfg_ack(o_cfg_ack),
    .o_xcenter(o_xcenter), .o_ycenter(o_ycenter),
    .o_busy(o_busy), .o_done(o_done), .o_overrun(o_overrun)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [9:0] xs(input int k);
    return o_xcenter[10*k +: 10];
  endfunction

  function automatic logic [9:0] ys(input int k);
    return o_ycenter[10*k +: 10];
  endfunction

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic cfg_write(input int slot, input int x, input int y, input int vx, input int vy,
                           output logic acked);
    i_cfg_we  = 1'b1;
    i_cfg_idx = 3'(slot);
    i_cfg_x   = 10'(x);
    i_cfg_y   = 10'(y);
    i_cfg_vx  = 4'(vx);
    i_cfg_vy  = 4'(vy);
    step();
    acked    = o_cfg_ack;
    i_cfg_we = 1'b0;
    step();
  endtask

  // Pulses frame start, counts busy cycles until done, then one extra cycle to catch a second done.
  task automatic run_frame(output int busy_cnt, output int done_cnt, output logic timed_out);
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
    busy_cnt  = 0;
    done_cnt  = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (o_busy) busy_cnt++;
      if (o_done) begin
        done_cnt++;
        timed_out = 1'b0;
        break;
      end
      step();
    end
    if (!timed_out) begin
      step();
      if (o_done) done_cnt++;
    end
  endtask

  task automatic test_reset();
    logic [39:0] exp_x, exp_y;
    exp_x = {4{10'd320}};
    exp_y = {4{10'd240}};
    i_rst = 1'b1;
    step();
    step();
    i_rst = 1'b0;
    step();
    checks++; if (o_busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
    checks++; if (o_done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %b want 0", o_done); end
    checks++; if (o_cfg_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", o_cfg_ack); end
    checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", o_overrun); end
    checks++; if (o_xcenter !== exp_x) begin errors++; $display("FAIL reset_x: got %h want %h", o_xcenter, exp_x); end
    checks++; if (o_ycenter !== exp_y) begin errors++; $display("FAIL reset_y: got %h want %h", o_ycenter, exp_y); end
  endtask

  task automatic test_idle_frame();
    int bc, dc;
    logic to;
    logic [39:0] exp_x;
    exp_x = {4{10'd320}};
    // frame start with the enable low must be ignored
    i_clkenable = 1'b0; i_frame_start = 1'b1;
    step();
    i_clkenable = 1'b1; i_frame_start = 1'b0;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL gated_start: busy %b want 0", o_busy); end
    run_frame(bc, dc, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL idle_timeout: timed_out %b want 0", to); end
    checks++; if (bc != 4)     begin errors++; $display("FAIL idle_busy_cycles: got %0d want 4", bc); end
    checks++; if (dc != 1)     begin errors++; $display("FAIL idle_done_pulses: got %0d want 1", dc); end
    checks++; if (o_xcenter !== exp_x) begin errors++; $display("FAIL idle_x: got %h want %h", o_xcenter, exp_x); end
  endtask

  task automatic test_config_move();
    int bc, dc;
    logic to, ack;
    cfg_write(1, 100, 100, 5, -3, ack);
    checks++; if (ack !== 1'b1)        begin errors++; $display("FAIL cfg_ack: got %b want 1", ack); end
    checks++; if (xs(1) !== 10'd320)   begin errors++; $display("FAIL cfg_not_visible: x1 %0d want 320", xs(1)); end
    run_frame(bc, dc, to);
    checks++; if (xs(1) !== 10'd105)   begin errors++; $display("FAIL move_x1: got %0d want 105", xs(1)); end
    checks++; if (ys(1) !== 10'd97)    begin errors++; $display("FAIL move_y1: got %0d want 97", ys(1)); end
    checks++; if (xs(0) !== 10'd320 || ys(2) !== 10'd240)
      begin errors++; $display("FAIL move_others: x0 %0d y2 %0d want 320 240", xs(0), ys(2)); end
  endtask

  task automatic test_bounce_right();
    int bc, dc;
    logic to, ack;
    cfg_write(0, 620, 240, 7, 0, ack);
    run_frame(bc, dc, to);
    checks++; if (xs(0) !== 10'd623) begin errors++; $display("FAIL bounce_clamp: x0 %0d want 623", xs(0)); end
    run_frame(bc, dc, to);
    checks++; if (xs(0) !== 10'd616) begin errors++; $display("FAIL bounce_return: x0 %0d want 616", xs(0)); end
  endtask

  task automatic test_sat_neg();
    int bc, dc;
    logic to, ack;
    cfg_write(2, 18, 240, -8, 0, ack);
    run_frame(bc, dc, to);
    checks++; if (xs(2) !== 10'd16) begin errors++; $display("FAIL satneg_clamp: x2 %0d want 16", xs(2)); end
    run_frame(bc, dc, to);
    checks++; if (xs(2) !== 10'd23) begin errors++; $display("FAIL satneg_plus7: x2 %0d want 23", xs(2)); end
  endtask

  task automatic test_out_of_range();
    logic ack;
    cfg_write(5, 10, 10, 1, 1, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL oor_ack: got %b want 0", ack); end
  endtask

  task automatic test_overrun_busy_cfg();
    int dc;
    logic seen_ovr, seen_ack, timed_out;
    i_frame_start = 1'b1;
    step();
    // now mid-pass: second frame start plus a config write to slot 3
    i_cfg_we = 1'b1; i_cfg_idx = 3'd3; i_cfg_x = 10'd500; i_cfg_y = 10'd50;
    i_cfg_vx = 4'd1; i_cfg_vy = 4'd1;
    step();
    seen_ovr = o_overrun;
    seen_ack = o_cfg_ack;
    i_frame_start = 1'b0; i_cfg_we = 1'b0;
    checks++; if (seen_ovr !== 1'b1) begin errors++; $display("FAIL overrun_pulse: got %b want 1", seen_ovr); end
    checks++; if (seen_ack !== 1'b0) begin errors++; $display("FAIL busy_cfg_ack: got %b want 0", seen_ack); end
    step();
    checks++; if (o_overrun !== 1'b0) begin errors++; $display("FAIL overrun_width: got %b want 0", o_overrun); end
    dc = 0;
    timed_out = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (o_done) begin dc++; timed_out = 1'b0; break; end
      step();
    end
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL overrun_done: timed_out %b want 0", timed_out); end
    checks++; if (xs(3) !== 10'd320 || ys(3) !== 10'd240)
      begin errors++; $display("FAIL busy_cfg_dropped: slot3 (%0d,%0d) want (320,240)", xs(3), ys(3)); end
    step();
  endtask

  task automatic test_reset_mid_pass();
    int bc, dc, bad;
    logic to;
    logic [39:0] exp_x, exp_y;
    exp_x = {4{10'd320}};
    exp_y = {4{10'd240}};
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
    step();
    i_clkenable = 1'b0; i_rst = 1'b1;
    step();
    i_rst = 1'b0; i_clkenable = 1'b1;
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", o_busy); end
    checks++; if (o_xcenter !== exp_x || o_ycenter !== exp_y)
      begin errors++; $display("FAIL midrst_centres: x %h y %h want %h %h", o_xcenter, o_ycenter, exp_x, exp_y); end
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (o_done || o_busy) bad++;
      step();
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL midrst_no_commit: %0d active cycles want 0", bad); end
    // velocities were cleared, so a full pass leaves everything centred
    run_frame(bc, dc, to);
    checks++; if (o_xcenter !== exp_x || o_ycenter !== exp_y)
      begin errors++; $display("FAIL midrst_vel_zero: x %h y %h want %h %h", o_xcenter, o_ycenter, exp_x, exp_y); end
  endtask

  task automatic test_gravity();
    int bc, dc;
    logic to;
    run_frame(bc, dc, to);
    checks++; if (ys(0) !== 10'd241) begin errors++; $display("FAIL gravity_f1: y0 %0d want 241", ys(0)); end
    run_frame(bc, dc, to);
    checks++; if (ys(0) !== 10'd243) begin errors++; $display("FAIL gravity_f2: y0 %0d want 243", ys(0)); end
    run_frame(bc, dc, to);
    checks++; if (ys(0) !== 10'd246) begin errors++; $display("FAIL gravity_f3: y0 %0d want 246", ys(0)); end
  endtask

  initial begin
    test_reset();
`ifdef SHAPE_MOTION_GRAVITY_EN
    test_gravity();
`else
    test_idle_frame();
    test_config_move();
    test_bounce_right();
    test_sat_neg();
    test_out_of_range();
    test_overrun_busy_cfg();
    test_reset_mid_pass();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
